// File: rtl/eei_pkg.sv
// Shared execution-environment types for the fetch and decode front end.
// Holds machine width, address/instruction types and aligner sizing.
package eei;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] Addr;
    typedef logic [31:0]     Inst;
    typedef logic [15:0]     HalfWord;

    localparam int ALIGN_BUF_HW = 4;

endpackage

// File: rtl/halfword_fifo.sv
// Shifting halfword queue: 0..2 pops and 0..2 pushes per cycle.
// Pops shift the queue first; pushes append after the surviving entries.
module halfword_fifo
    import eei::*;
#(
    parameter int DEPTH = ALIGN_BUF_HW,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [1:0]    push_n,
    input  HalfWord       push_a,
    input  HalfWord       push_b,
    input  logic [1:0]    pop_n,
    output HalfWord       head0,
    output HalfWord       head1,
    output logic [CW-1:0] count
);

    HalfWord q     [DEPTH];
    HalfWord q_nxt [DEPTH];
    int      base;
    int      cnt_nxt;

    always_comb begin
        base    = int'(count) - int'(pop_n);
        cnt_nxt = base + int'(push_n);
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j == i + int'(pop_n)) q_nxt[i] = q[j];
            end
            if (push_n != 2'd0 && i == base) q_nxt[i] = push_a;
            if (push_n == 2'd2 && i == base + 1) q_nxt[i] = push_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= CW'(cnt_nxt);
            q     <= q_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr) begin
            assert (cnt_nxt >= 0 && cnt_nxt <= DEPTH);
        end
    end

    assign head0 = q[0];
    assign head1 = q[1];

endmodule

// File: rtl/inst_aligner.sv
// Slices in-order fetch words into one RVC or 32-bit instruction per transfer.
// Tracks instruction PC and the next expected fetch address; drops stale words.
module inst_aligner
    import eei::*;
#(
    parameter Addr RESET_PC = '0,
    parameter int  BUF_HW   = ALIGN_BUF_HW
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  Addr     flush_pc,
    input  logic    fetch_valid,
    output logic    fetch_ready,
    input  Addr     fetch_addr,
    input  Inst     fetch_data,
    output logic    out_valid,
    input  logic    out_ready,
    output Addr     out_pc,
    output Inst     out_bits,
    output logic    out_is_rvc
);

    localparam int CW = $clog2(BUF_HW + 1);

    Addr           cur_pc;
    Addr           exp_addr;
    logic          drop_lo;
    logic [CW-1:0] count;
    HalfWord       head0;
    HalfWord       head1;
    logic          head_rvc;
    logic          addr_ok;
    logic          push_fire;
    logic          pop_fire;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    HalfWord       push_a;
    HalfWord       push_b;

    assign head_rvc  = head0[1:0] != 2'b11;
    assign addr_ok   = fetch_addr == exp_addr;
    // Stale words are always accepted so a redirect never stalls on them.
    assign fetch_ready = (BUF_HW - int'(count) >= 2) || !addr_ok;
    assign push_fire = fetch_valid && fetch_ready && addr_ok && !flush;

    assign out_valid  = !flush && (count >= CW'(2) ||
                        (count == CW'(1) && head_rvc));
    assign pop_fire   = out_valid && out_ready;
    assign out_bits   = head_rvc ? {16'b0, head0} : {head1, head0};
    assign out_is_rvc = head_rvc;
    assign out_pc     = cur_pc;

    always_comb begin
        push_n = 2'd0;
        push_a = fetch_data[15:0];
        push_b = fetch_data[31:16];
        if (push_fire) begin
            if (drop_lo) begin
                push_n = 2'd1;
                push_a = fetch_data[31:16];
            end else begin
                push_n = 2'd2;
            end
        end
        pop_n = pop_fire ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
    end

    halfword_fifo #(
        .DEPTH (BUF_HW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .push_n (push_n),
        .push_a (push_a),
        .push_b (push_b),
        .pop_n  (pop_n),
        .head0  (head0),
        .head1  (head1),
        .count  (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_pc   <= RESET_PC;
            exp_addr <= {RESET_PC[XLEN-1:2], 2'b00};
            drop_lo  <= RESET_PC[1];
        end else if (flush) begin
            cur_pc   <= flush_pc;
            exp_addr <= {flush_pc[XLEN-1:2], 2'b00};
            drop_lo  <= flush_pc[1];
        end else begin
            if (pop_fire) begin
                cur_pc <= cur_pc + (head_rvc ? Addr'(2) : Addr'(4));
            end
            if (push_fire) begin
                exp_addr <= exp_addr + Addr'(4);
                drop_lo  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_aligner.sv
// Directed scoreboard bench for inst_aligner.
// Expectations are queued as words are driven and checked on each out transfer.
module tb_inst_aligner;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_bits;
    logic        out_is_rvc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] bits;
        logic        rvc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    inst_aligner #(
        .RESET_PC (32'h0),
        .BUF_HW   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_bits    (out_bits),
        .out_is_rvc  (out_is_rvc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] bits,
                              input logic rvc);
        exp_t e;
        e.pc   = pc;
        e.bits = bits;
        e.rvc  = rvc;
        sb.push_back(e);
    endtask

    // Scoreboard side: every out transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("out_unexpected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_bits", out_bits, e.bits);
                chk("out_is_rvc", 32'(out_is_rvc), 32'(e.rvc));
            end
        end
    end

    task automatic send_word(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        fetch_valid = 1'b1;
        fetch_addr  = a;
        fetch_data  = d;
        @(negedge clk);
        while (!fetch_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        flush_pc    = '0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        fetch_data  = '0;
        out_ready   = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: aligned 32-bit instruction, one-cycle latency
        expect_out(32'h0, 32'h00450513, 1'b0);
        send_word(32'h0, 32'h00450513);
        @(negedge clk);
        chk("t1_latency_valid", 32'(out_valid), 32'd1);
        wait_drain();

        // 2: two RVC instructions in one word
        flush_to(32'h0);
        expect_out(32'h0, 32'h00000505, 1'b1);
        expect_out(32'h2, 32'h00004501, 1'b1);
        send_word(32'h0, 32'h45010505);
        wait_drain();

        // 3: 32-bit instruction straddling two words
        flush_to(32'h0);
        expect_out(32'h0, 32'h00000505, 1'b1);
        expect_out(32'h2, 32'h00450513, 1'b0);
        expect_out(32'h6, 32'h00000001, 1'b1);
        send_word(32'h0, 32'h05130505);
        send_word(32'h4, 32'h00010045);
        wait_drain();

        // 4: redirect to odd halfword, stale word dropped
        flush_to(32'h102);
        send_word(32'h8, 32'hDEADBEEF);
        @(negedge clk);
        chk("t4_stale_no_out", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        expect_out(32'h102, 32'h00000001, 1'b1);
        send_word(32'h100, 32'h00014501);
        wait_drain();
        @(negedge clk);
        chk("t4_empty_after", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // 5: back-pressure with a full queue, then drain 1/cycle
        flush_to(32'h200);
        out_ready = 1'b0;
        expect_out(32'h200, 32'h00450513, 1'b0);
        expect_out(32'h204, 32'h00A00593, 1'b0);
        send_word(32'h200, 32'h00450513);
        send_word(32'h204, 32'h00A00593);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h208;
        fetch_data  = 32'h00000013;
        @(negedge clk);
        chk("t5_full_ready", 32'(fetch_ready), 32'd0);
        chk("t5_hold_valid", 32'(out_valid), 32'd1);
        chk("t5_hold_bits0", out_bits, 32'h00450513);
        @(negedge clk);
        chk("t5_hold_bits1", out_bits, 32'h00450513);
        chk("t5_hold_pc", out_pc, 32'h200);
        @(posedge clk);
        #1;
        fetch_addr = 32'h300;
        @(negedge clk);
        chk("t5_stale_ready", 32'(fetch_ready), 32'd1);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        out_ready   = 1'b1;
        @(negedge clk);
        chk("t5_drain0_valid", 32'(out_valid), 32'd1);
        chk("t5_drain0_pc", out_pc, 32'h200);
        @(negedge clk);
        chk("t5_drain1_valid", 32'(out_valid), 32'd1);
        chk("t5_drain1_pc", out_pc, 32'h204);
        @(negedge clk);
        chk("t5_drained", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // PC and expected address wrap at the top of the address space
        flush_to(32'hFFFF_FFFC);
        expect_out(32'hFFFF_FFFC, 32'h00450513, 1'b0);
        expect_out(32'h0, 32'h00000505, 1'b1);
        expect_out(32'h2, 32'h00004501, 1'b1);
        send_word(32'hFFFF_FFFC, 32'h00450513);
        send_word(32'h0, 32'h45010505);
        wait_drain();

        // 6: reset while a 32-bit head waits for its upper half
        flush_to(32'h0);
        expect_out(32'h0, 32'h00000505, 1'b1);
        send_word(32'h0, 32'h05130505);
        wait_drain();
        @(negedge clk);
        chk("t6_partial_valid", 32'(out_valid), 32'd0);
        chk("t6_partial_pc", out_pc, 32'h2);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_pc", out_pc, 32'h0);
        chk("t6_rst_ready", 32'(fetch_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out(32'h0, 32'h00450513, 1'b0);
        send_word(32'h0, 32'h00450513);
        wait_drain();

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
